// File: rtl/button_debouncer_pkg.sv
// Shared types for the button debouncer: FSM state encoding and a level helper.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    ST_ZERO  = 2'b00,
    ST_WAIT1 = 2'b01,
    ST_ONE   = 2'b10,
    ST_WAIT0 = 2'b11
  } db_state_e;

  // The debounced level is high while settled high or while qualifying a release.
  function automatic logic state_level(input db_state_e st);
    return (st == ST_ONE) || (st == ST_WAIT0);
  endfunction

endpackage

// File: rtl/synchronizer.sv
// N-flop asynchronous-reset synchroniser chain for bringing raw board inputs into the clk domain.
module synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  // Shift the raw input one flop further along the chain each cycle.
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  // Chain storage; cleared asynchronously so the FSM sees a known low after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Button debouncer: synchronised input qualified by a four-state FSM and a quiet-time
// counter clocked by en, with registered level and one-cycle rise/fall pulses.
module button_debouncer #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CNT      = 2_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic sw,
  output logic db_level,
  output logic db_rise,
  output logic db_fall
);

  import button_debouncer_pkg::*;

  localparam int CNT_W = $clog2(DB_CNT) + 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DB_CNT - 1);

  logic             sw_s;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw),
    .q     (sw_s)
  );

  // Next-state logic: a mismatch in WAIT* aborts before en/cnt are considered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_ZERO: begin
        if (sw_s) begin
          state_d = ST_WAIT1;
          cnt_d   = CNT_RELOAD;
        end else begin
          state_d = ST_ZERO;
        end
      end
      ST_WAIT1: begin
        if (!sw_s) begin
          state_d = ST_ZERO;
        end else if (en && (cnt_q == '0)) begin
          state_d = ST_ONE;
          rise_d  = 1'b1;
        end else if (en) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_ONE: begin
        if (!sw_s) begin
          state_d = ST_WAIT0;
          cnt_d   = CNT_RELOAD;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_WAIT0: begin
        if (sw_s) begin
          state_d = ST_ONE;
        end else if (en && (cnt_q == '0)) begin
          state_d = ST_ZERO;
          fall_d  = 1'b1;
        end else if (en) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_ZERO;
        cnt_d   = '0;
      end
    endcase
    level_d = state_level(state_d);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ZERO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign db_level = level_q;
  assign db_rise  = rise_q;
  assign db_fall  = fall_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (SYNC_STAGES=2, DB_CNT=4) against a
// credit-counting reference model of the debounce rules.
module tb_button_debouncer;

  localparam int SYNC = 2;
  localparam int DBC  = 4;
  localparam int LAT  = SYNC + DBC + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic sw = 1'b0;
  logic db_level, db_rise, db_fall;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  logic m_sync [SYNC];
  logic m_level, m_rise, m_fall, m_pending;
  int   m_credit;

  button_debouncer #(.SYNC_STAGES(SYNC), .DB_CNT(DBC)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .sw       (sw),
    .db_level (db_level),
    .db_rise  (db_rise),
    .db_fall  (db_fall)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
    m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
    m_pending = 1'b0; m_credit = 0;
  endtask

  // One clock edge of the model: the level flips once sw_s has disagreed with it
  // on the entry edge plus DBC further en-qualified edges, uninterrupted.
  task automatic model_edge(input logic s, input logic e);
    logic sws;
    if (reset) begin
      model_clear();
    end else begin
      sws = m_sync[SYNC-1];
      m_rise = 1'b0; m_fall = 1'b0;
      if (sws == m_level) begin
        m_pending = 1'b0;
      end else if (!m_pending) begin
        m_pending = 1'b1;
        m_credit = 0;
      end else if (e) begin
        m_credit++;
        if (m_credit == DBC) begin
          m_level = ~m_level;
          m_rise = m_level;
          m_fall = ~m_level;
          m_pending = 1'b0;
        end
      end
      for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
      m_sync[0] = s;
    end
  endtask

  task automatic tick(input logic s, input logic e);
    sw = s; en = e;
    @(posedge clk);
    model_edge(s, e);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_clear();
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, i[0]);
      vectors++;
      if ({db_level, db_rise, db_fall} !== 3'b000) begin
        errors++;
        $display("FAIL reset cyc%0d got=%b exp=000", i, {db_level, db_rise, db_fall});
      end
    end
    sw = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1);
      vectors++;
      if ({db_level, db_rise, db_fall} !== {m_level, m_rise, m_fall}) begin
        errors++;
        $display("FAIL reset_release cyc%0d got=%b exp=%b", i, {db_level, db_rise, db_fall}, {m_level, m_rise, m_fall});
      end
    end
  endtask

  task automatic test_clean_press();
    int first = -1;
    int rises = 0;
    int falls = 0;
    for (int i = 1; i <= 14; i++) begin
      tick(1'b1, 1'b1);
      vectors++;
      if ({db_level, db_rise, db_fall} !== {m_level, m_rise, m_fall}) begin
        errors++;
        $display("FAIL press cyc%0d got=%b exp=%b", i, {db_level, db_rise, db_fall}, {m_level, m_rise, m_fall});
      end
      if (db_level === 1'b1 && first < 0) first = i;
      if (db_rise === 1'b1) rises++;
      if (db_fall === 1'b1) falls++;
    end
    vectors++;
    if (first != LAT || rises != 1 || falls != 0) begin
      errors++;
      $display("FAIL press_latency edge=%0d rises=%0d falls=%0d exp edge=%0d rises=1 falls=0", first, rises, falls, LAT);
    end
  endtask

  task automatic test_release();
    int first = -1;
    int rises = 0;
    int falls = 0;
    for (int i = 1; i <= 14; i++) begin
      tick(1'b0, 1'b1);
      vectors++;
      if ({db_level, db_rise, db_fall} !== {m_level, m_rise, m_fall}) begin
        errors++;
        $display("FAIL release cyc%0d got=%b exp=%b", i, {db_level, db_rise, db_fall}, {m_level, m_rise, m_fall});
      end
      if (db_level === 1'b0 && first < 0) first = i;
      if (db_rise === 1'b1) rises++;
      if (db_fall === 1'b1) falls++;
    end
    vectors++;
    if (first != LAT || rises != 0 || falls != 1) begin
      errors++;
      $display("FAIL release_latency edge=%0d rises=%0d falls=%0d exp edge=%0d rises=0 falls=1", first, rises, falls, LAT);
    end
  endtask

  task automatic test_bounce();
    logic pat [3] = '{1'b1, 1'b1, 1'b0};
    int first = -1;
    for (int i = 0; i < 3; i++) begin
      tick(pat[i], 1'b1);
      vectors++;
      if ({db_level, db_rise, db_fall} !== {m_level, m_rise, m_fall}) begin
        errors++;
        $display("FAIL bounce cyc%0d got=%b exp=%b", i, {db_level, db_rise, db_fall}, {m_level, m_rise, m_fall});
      end
    end
    for (int i = 1; i <= 14; i++) begin
      tick(1'b1, 1'b1);
      vectors++;
      if ({db_level, db_rise, db_fall} !== {m_level, m_rise, m_fall}) begin
        errors++;
        $display("FAIL bounce_hold cyc%0d got=%b exp=%b", i, {db_level, db_rise, db_fall}, {m_level, m_rise, m_fall});
      end
      if (db_level === 1'b1 && first < 0) first = i;
    end
    vectors++;
    if (first != LAT) begin
      errors++;
      $display("FAIL bounce_latency edge=%0d exp=%0d", first, LAT);
    end
  endtask

  task automatic test_gated_en();
    int rise_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, (i % 4) == 3);
      vectors++;
      if ({db_level, db_rise, db_fall} !== {m_level, m_rise, m_fall}) begin
        errors++;
        $display("FAIL gated cyc%0d got=%b exp=%b", i, {db_level, db_rise, db_fall}, {m_level, m_rise, m_fall});
      end
      if (db_rise === 1'b1) rise_cyc = i;
    end
    // WAIT1 is entered at cycle 2; en pulses land on 3,7,11,15, so the 4th is cycle 15.
    vectors++;
    if (rise_cyc != 15) begin
      errors++;
      $display("FAIL gated_rise cyc=%0d exp=15", rise_cyc);
    end
  endtask

  task automatic test_reset_in_wait();
    int first = -1;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1);
    reset = 1'b1;
    model_clear();
    #1;
    vectors++;
    if ({db_level, db_rise, db_fall} !== 3'b000) begin
      errors++;
      $display("FAIL rst_wait_immediate got=%b exp=000", {db_level, db_rise, db_fall});
    end
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b1, 1'b1);
      vectors++;
      if ({db_level, db_rise, db_fall} !== {m_level, m_rise, m_fall}) begin
        errors++;
        $display("FAIL rst_wait cyc%0d got=%b exp=%b", i, {db_level, db_rise, db_fall}, {m_level, m_rise, m_fall});
      end
      if (db_rise === 1'b1 && first < 0) first = i;
    end
    vectors++;
    if (first != LAT) begin
      errors++;
      $display("FAIL rst_wait_rise edge=%0d exp=%0d", first, LAT);
    end
  endtask

  task automatic test_random();
    logic s = 1'b0;
    int run = 0;
    for (int i = 0; i < 600; i++) begin
      if (run == 0) begin
        s = ~s;
        run = $urandom_range(1, 9);
      end
      run--;
      tick(s, ($urandom_range(0, 9) < 7));
      vectors++;
      if ({db_level, db_rise, db_fall} !== {m_level, m_rise, m_fall}) begin
        errors++;
        $display("FAIL random cyc%0d got=%b exp=%b", i, {db_level, db_rise, db_fall}, {m_level, m_rise, m_fall});
      end
      vectors++;
      if (db_rise === 1'b1 && db_fall === 1'b1) begin
        errors++;
        $display("FAIL random_both cyc%0d rise=1 fall=1 exp not both", i);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b1);
    test_gated_en();
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b1);
    test_reset_in_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
